// File: rtl/adc_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sched_pkg
//  Description : Shared types and constants for the ADC sample scheduler:
//                FSM state encoding, sample width, default period limits and
//                the saturating drop-counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_sched_pkg;

    localparam int DATA_W         = 12;
    localparam int PERIOD_W_DEF   = 16;
    localparam int MIN_PERIOD_DEF = 8;
    localparam int TIMEOUT_DEF    = 1024;
    localparam int DROP_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_t;

    // Adds up to three lost samples to the drop counter, pinning at all-ones.
    function automatic logic [DROP_W-1:0] sat_add_drop(
        input logic [DROP_W-1:0] base,
        input logic [1:0]        inc
    );
        logic [DROP_W:0] sum;
        sum = {1'b0, base} + {{(DROP_W-1){1'b0}}, inc};
        if (sum[DROP_W]) begin
            return '1;
        end
        return sum[DROP_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sample_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_scheduler_if
//  Description : Bundles the control, ADC-side and sample-stream signals of
//                the scheduler. 'master' is the scheduler's view, 'slave' is
//                the view of the surrounding system (ADC, pipeline, CPU regs).
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_sample_scheduler_if
    import adc_sched_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF
);
    logic                enable;
    logic [PERIOD_W-1:0] period;
    logic                clear_flags;
    logic                adc_start;
    logic                adc_ready;
    logic [DATA_W-1:0]   adc_data;
    logic [DATA_W-1:0]   sample;
    logic                sample_valid;
    logic                sample_ready;
    logic                busy;
    logic                overrun;
    logic                timeout;
    logic [DROP_W-1:0]   drop_count;

    modport master (
        input  enable, period, clear_flags, adc_ready, adc_data, sample_ready,
        output adc_start, sample, sample_valid, busy, overrun, timeout, drop_count
    );

    modport slave (
        output enable, period, clear_flags, adc_ready, adc_data, sample_ready,
        input  adc_start, sample, sample_valid, busy, overrun, timeout, drop_count
    );

endinterface
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : Two-entry synchronous FIFO with a registered head. A push
//                into a full FIFO is accepted only if a pop happens in the
//                same cycle; otherwise the pushed word is discarded and
//                o_drop pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int WIDTH = 12
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_head,
    output logic                  o_valid,
    output logic                  o_full,
    output logic                  o_drop
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_mem0;
    logic [WIDTH-1:0] r_mem1;

    logic w_pop;
    logic w_full;
    logic w_push_ok;

    assign w_full    = (r_count == 2'd2);
    assign w_pop     = i_pop && (r_count != 2'd0);
    assign w_push_ok = i_push && (!w_full || w_pop);

    assign o_head  = r_mem0;
    assign o_valid = (r_count != 2'd0);
    assign o_full  = w_full;
    assign o_drop  = i_push && w_full && !w_pop;

    // Storage and occupancy; r_mem0 is always the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_mem0  <= '0;
            r_mem1  <= '0;
        end else begin
            case ({w_push_ok, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem1 <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_scheduler
//  Description : Paces ADC conversions at a programmable period, captures
//                each result into a 2-deep FIFO for the effects pipeline and
//                reports missed slots, dropped samples and hung conversions.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int PERIOD_W   = PERIOD_W_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    adc_sample_scheduler_if.master bus
);

    localparam int                  c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST = c_TO_W'(TIMEOUT - 1);
    localparam logic [PERIOD_W-1:0] c_MIN_P   = PERIOD_W'(MIN_PERIOD);

    sched_state_t r_state;
    sched_state_t w_next;

    logic [PERIOD_W-1:0] r_pcnt;
    logic                r_run;
    logic [c_TO_W-1:0]   r_tcnt;
    logic                r_overrun;
    logic                r_timeout;
    logic [DROP_W-1:0]   r_drops;

    logic [PERIOD_W-1:0] w_reload;
    logic                w_tick;
    logic                w_start;
    logic                w_busy;
    logic                w_push;
    logic                w_to_evt;
    logic                w_miss;
    logic                w_drop;
    logic                w_pop;
    logic                w_full;
    logic                w_valid;
    logic [DATA_W-1:0]   w_head;
    logic [1:0]          w_loss;
    logic [DROP_W-1:0]   w_drop_base;

    // The period is clamped and sampled only at reload, so a new value
    // takes effect from the following slot.
    assign w_reload = ((bus.period < c_MIN_P) ? c_MIN_P : bus.period) - PERIOD_W'(1);

    // The first enabled cycle is itself a slot; afterwards a slot occurs
    // every time the counter reaches zero.
    assign w_tick = bus.enable && (!r_run || (r_pcnt == '0));

    // Period counter: held at its reset value while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= '0;
            r_run  <= 1'b0;
        end else if (!bus.enable) begin
            r_pcnt <= '0;
            r_run  <= 1'b0;
        end else if (w_tick) begin
            r_pcnt <= w_reload;
            r_run  <= 1'b1;
        end else begin
            r_pcnt <= r_pcnt - PERIOD_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and per-state strobes; a slot that arrives while a
    // conversion is still in flight is recorded as missed.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_busy   = 1'b0;
        w_push   = 1'b0;
        w_to_evt = 1'b0;
        w_miss   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                w_start = 1'b1;
                w_busy  = 1'b1;
                w_miss  = w_tick;
                w_next  = ST_WAIT;
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                w_miss = w_tick;
                if (bus.adc_ready) begin
                    w_push = 1'b1;
                    w_next = ST_IDLE;
                end else if (r_tcnt == c_TO_LAST) begin
                    w_to_evt = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Conversion watchdog: zeroed in START, counts cycles spent in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (r_state == ST_START) begin
            r_tcnt <= '0;
        end else if ((r_state == ST_WAIT) && (r_tcnt != c_TO_LAST)) begin
            r_tcnt <= r_tcnt + c_TO_W'(1);
        end
    end

    sample_fifo #(
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (bus.adc_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    assign w_pop = w_valid && bus.sample_ready;

    // A missed slot and a FIFO-full drop can coincide; both are counted.
    assign w_loss      = {1'b0, w_miss} + {1'b0, w_drop};
    assign w_drop_base = bus.clear_flags ? '0 : r_drops;

    // Sticky status; a new event in the clearing cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            r_drops   <= '0;
        end else begin
            if (w_loss != 2'd0) begin
                r_overrun <= 1'b1;
                r_drops   <= sat_add_drop(w_drop_base, w_loss);
            end else if (bus.clear_flags) begin
                r_overrun <= 1'b0;
                r_drops   <= '0;
            end
            if (w_to_evt) begin
                r_timeout <= 1'b1;
            end else if (bus.clear_flags) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign bus.adc_start    = w_start;
    assign bus.busy         = w_busy;
    assign bus.sample       = w_head;
    assign bus.sample_valid = w_valid;
    assign bus.overrun      = r_overrun;
    assign bus.timeout      = r_timeout;
    assign bus.drop_count   = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_sample_scheduler
//  Description : Self-checking bench for adc_sample_scheduler. A behavioural
//                model tracks slot times as absolute cycle numbers, the FIFO
//                as a queue and the flags as plain integers; every cycle the
//                DUT outputs are compared against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_scheduler;
    import adc_sched_pkg::*;

    localparam int c_TO   = 1024;
    localparam int c_MINP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    adc_sample_scheduler_if #(.PERIOD_W(16)) bus ();

    adc_sample_scheduler #(
        .PERIOD_W   (16),
        .MIN_PERIOD (c_MINP),
        .TIMEOUT    (c_TO)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: 0 idle, 1 start, 2 waiting for the ADC.
    int                m_st;
    bit                m_run;
    int                m_next_tick;
    int                m_start_cyc;
    logic [DATA_W-1:0] m_q[$];
    bit                m_ovr;
    bit                m_to;
    int                m_drops;

    // ADC behaviour and stimulus knobs.
    int ready_at = -1;
    int lat_q[$];
    int lat_lo   = 1;
    int lat_hi   = 1;
    int hang_pct = 0;
    bit rnd_mode = 1'b0;
    int starts[$];
    int n_pops   = 0;
    int e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_run   = 1'b0;
        m_q.delete();
        m_ovr   = 1'b0;
        m_to    = 1'b0;
        m_drops = 0;
        ready_at = -1;
    endtask

    function automatic int pick_lat();
        if (lat_q.size() > 0) begin
            return lat_q.pop_front();
        end
        if ((hang_pct > 0) && ($urandom_range(0, 99) < hang_pct)) begin
            return 0;
        end
        return $urandom_range(lat_lo, lat_hi);
    endfunction

    // Advances the model by one cycle using the inputs presented this cycle.
    task automatic model_step();
        int p;
        int loss;
        int nst;
        bit tick;
        bit push;
        bit toev;
        if (rst) begin
            model_reset();
            return;
        end
        p    = (int'(bus.period) < c_MINP) ? c_MINP : int'(bus.period);
        tick = bus.enable && (!m_run || (cyc == m_next_tick));
        if (!bus.enable) begin
            m_run = 1'b0;
        end else if (tick) begin
            m_run       = 1'b1;
            m_next_tick = cyc + p;
        end
        loss = 0;
        push = 1'b0;
        toev = 1'b0;
        nst  = m_st;
        case (m_st)
            0: if (tick) nst = 1;
            1: begin
                if (tick) loss++;
                m_start_cyc = cyc;
                nst = 2;
            end
            default: begin
                if (tick) loss++;
                if (bus.adc_ready) begin
                    push = 1'b1;
                    nst  = 0;
                end else if (cyc == m_start_cyc + c_TO) begin
                    toev = 1'b1;
                    nst  = 0;
                end
            end
        endcase
        if ((m_q.size() > 0) && bus.sample_ready) begin
            void'(m_q.pop_front());
        end
        if (push) begin
            if (m_q.size() < 2) m_q.push_back(bus.adc_data);
            else loss++;
        end
        if (loss > 0) begin
            m_ovr   = 1'b1;
            m_drops = (bus.clear_flags ? 0 : m_drops) + loss;
            if (m_drops > 255) m_drops = 255;
        end else if (bus.clear_flags) begin
            m_ovr   = 1'b0;
            m_drops = 0;
        end
        if (toev) m_to = 1'b1;
        else if (bus.clear_flags) m_to = 1'b0;
        m_st = nst;
    endtask

    task automatic compare_outputs();
        check("adc_start", bus.adc_start, (m_st == 1));
        check("busy", bus.busy, (m_st != 0));
        check("sample_valid", bus.sample_valid, (m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("sample", bus.sample, m_q[0]);
        end
        check("overrun", bus.overrun, m_ovr);
        check("timeout", bus.timeout, m_to);
        check("drop_count", bus.drop_count, m_drops);
    endtask

    task automatic run(input int n);
        int l;
        for (int i = 0; i < n; i++) begin
            bus.adc_ready = (cyc == ready_at);
            bus.adc_data  = 12'($urandom);
            if (rnd_mode) begin
                if ($urandom_range(0, 29) == 0) bus.adc_ready = 1'b1;
                bus.sample_ready = ($urandom_range(0, 3) != 0);
                bus.clear_flags  = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
                if ($urandom_range(0, 49) == 0) bus.period = 16'($urandom_range(0, 40));
                rst = ($urandom_range(0, 1499) == 0);
            end
            @(negedge clk);
            compare_outputs();
            if (bus.adc_start) starts.push_back(cyc);
            if (bus.sample_valid && bus.sample_ready) n_pops++;
            if (m_st == 1) begin
                l = pick_lat();
                ready_at = (l == 0) ? -1 : cyc + l;
            end
            model_step();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic pulse_clear();
        bus.clear_flags = 1'b1;
        run(1);
        bus.clear_flags = 1'b0;
    endtask

    initial begin
        bus.enable       = 1'b0;
        bus.period       = 16'd100;
        bus.clear_flags  = 1'b0;
        bus.adc_ready    = 1'b0;
        bus.adc_data     = '0;
        bus.sample_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_sample", bus.sample, 0);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_start", bus.adc_start, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_drops", bus.drop_count, 0);

        // Nominal pacing: period 100, ADC answers after 40 cycles.
        lat_lo = 40; lat_hi = 40;
        starts.delete();
        e = cyc;
        bus.enable = 1'b1;
        run(320);
        check("A_nstarts", starts.size(), 4);
        if (starts.size() >= 3) begin
            check("A_start0", starts[0], e + 1);
            check("A_start1", starts[1], e + 101);
            check("A_start2", starts[2], e + 201);
        end
        check("A_ovr", bus.overrun, 0);
        check("A_drops", bus.drop_count, 0);
        bus.enable = 1'b0;
        run(60);

        // Period below the minimum is clamped.
        bus.period = 16'd3;
        lat_lo = 1; lat_hi = 6;
        starts.delete();
        bus.enable = 1'b1;
        run(60);
        if (starts.size() >= 3) begin
            check("B_gap1", starts[1] - starts[0], 8);
            check("B_gap2", starts[2] - starts[1], 8);
        end else begin
            check("B_nstarts", starts.size(), 3);
        end
        bus.enable = 1'b0;
        run(20);

        // Slow ADC: every other slot is missed.
        bus.period = 16'd50;
        lat_lo = 70; lat_hi = 70;
        e = cyc;
        bus.enable = 1'b1;
        run(260);
        check("C_ovr", bus.overrun, 1);
        check("C_drops", bus.drop_count, 3);
        pulse_clear();
        check("C_clr_ovr", bus.overrun, 0);
        check("C_clr_drops", bus.drop_count, 0);
        bus.enable = 1'b0;
        run(100);

        // Back-pressure: third sample is dropped, first two kept in order.
        pulse_clear();
        bus.sample_ready = 1'b0;
        bus.period = 16'd20;
        lat_lo = 5; lat_hi = 5;
        bus.enable = 1'b1;
        run(55);
        check("D_drops", bus.drop_count, 1);
        check("D_valid", bus.sample_valid, 1);
        bus.enable = 1'b0;
        bus.sample_ready = 1'b1;
        run(5);
        check("D_empty", bus.sample_valid, 0);

        // Hung conversion followed by a normal slot.
        bus.period = 16'd1100;
        lat_q.push_back(0);
        lat_lo = 10; lat_hi = 10;
        starts.delete();
        e = cyc;
        bus.enable = 1'b1;
        run(1025);
        check("E_to_pre", bus.timeout, 0);
        run(1);
        check("E_to", bus.timeout, 1);
        check("E_idle", bus.busy, 0);
        run(80);
        check("E_nstarts", starts.size(), 2);
        if (starts.size() >= 2) check("E_start1", starts[1], e + 1101);
        bus.enable = 1'b0;
        run(20);

        // Reset while waiting for the ADC with samples in the FIFO.
        bus.sample_ready = 1'b0;
        bus.period = 16'd30;
        lat_lo = 5; lat_hi = 5;
        bus.enable = 1'b1;
        run(33);
        check("F_busy_pre", bus.busy, 1);
        bus.enable = 1'b0;
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        check("F_sample", bus.sample, 0);
        check("F_valid", bus.sample_valid, 0);
        check("F_busy", bus.busy, 0);
        check("F_to", bus.timeout, 0);
        check("F_drops", bus.drop_count, 0);
        bus.sample_ready = 1'b1;
        run(5);

        // Enable dropped mid-conversion: result still delivered, no restart.
        lat_lo = 15; lat_hi = 15;
        starts.delete();
        n_pops = 0;
        bus.enable = 1'b1;
        run(8);
        bus.enable = 1'b0;
        run(60);
        check("F2_starts", starts.size(), 1);
        check("F2_pops", n_pops, 1);

        // Randomised traffic.
        lat_lo = 1; lat_hi = 60; hang_pct = 3;
        rnd_mode = 1'b1;
        run(4000);
        rnd_mode = 1'b0;
        rst = 1'b0;
        bus.enable = 1'b0;
        bus.clear_flags = 1'b0;
        bus.sample_ready = 1'b1;
        hang_pct = 0;
        run(1100);

        // Drop counter saturation.
        pulse_clear();
        bus.period = 16'd0;
        lat_lo = 200; lat_hi = 200;
        bus.enable = 1'b1;
        run(3000);
        check("H_sat", bus.drop_count, 255);
        check("H_ovr", bus.overrun, 1);
        bus.enable = 1'b0;
        run(250);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
